// File: rtl/disp_hex_demux.sv
`default_nettype none
// ============================================================================
// Module      : disp_hex_demux
// Description : Receive-side decoder for a four-digit multiplexed
//               seven-segment bus. Registers {an, sseg} every edge, waits
//               until the pair has been stable for STABLE_CYCLES edges,
//               then decodes the active digit back to a hex code + dp and
//               reassembles complete four-digit frames.
// Ports       : clk         - system clock
//               reset       - synchronous, active-low reset
//               an[3:0]     - digit enables, active high, one-hot
//               sseg[7:0]   - segments, active high {dp,a,b,c,d,e,f,g}
//               hex3..hex0  - last decoded code per digit
//               dp_out[3:0] - last captured decimal point per digit
//               frame_valid - 1-cycle pulse, all four digits captured
//               err         - 1-cycle pulse, illegal sample detected
// Revision    : 1.0 - initial release
// ============================================================================
module disp_hex_demux #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [7:0] sseg,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] dp_out,
    output logic       frame_valid,
    output logic       err
);

    localparam int                 c_CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_FIRE = c_CNT_W'(STABLE_CYCLES - 1);

    logic [11:0]        r_sreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_seen;
    logic [3:0]         r_hex [4];
    logic [3:0]         r_dp;
    logic               r_frame_valid;
    logic               r_err;

    logic [11:0] w_in;
    logic        w_changed;
    logic        w_sample;
    logic [3:0]  w_an;
    logic        w_onehot;
    logic [1:0]  w_idx;
    logic [3:0]  w_bit;
    logic [3:0]  w_seen_nxt;
    logic [3:0]  w_code;
    logic        w_match;

    assign w_in      = {an, sseg};
    assign w_changed = (w_in != r_sreg);
    // The counter saturates at STABLE_CYCLES, so this fires once per
    // stable interval no matter how long the value is held.
    assign w_sample  = !w_changed && (r_cnt == c_CNT_FIRE);
    assign w_an      = r_sreg[11:8];
    assign w_onehot  = (w_an != 4'd0) && ((w_an & (w_an - 4'd1)) == 4'd0);
    assign w_bit     = 4'd1 << w_idx;
    assign w_seen_nxt = r_seen | w_bit;

    always_comb begin
        w_idx = 2'd0;
        case (w_an)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    // Segment pattern (a..g) back to hex code.
    always_comb begin
        w_code  = 4'd0;
        w_match = 1'b1;
        case (r_sreg[6:0])
            7'b1111110: w_code = 4'h0;
            7'b0110000: w_code = 4'h1;
            7'b1101101: w_code = 4'h2;
            7'b1111001: w_code = 4'h3;
            7'b0110011: w_code = 4'h4;
            7'b1011011: w_code = 4'h5;
            7'b1011111: w_code = 4'h6;
            7'b1110000: w_code = 4'h7;
            7'b1111111: w_code = 4'h8;
            7'b1111011: w_code = 4'h9;
            7'b1110111: w_code = 4'hA;
            7'b0011111: w_code = 4'hB;
            7'b1001110: w_code = 4'hC;
            7'b0111101: w_code = 4'hD;
            7'b1001111: w_code = 4'hE;
            7'b1000111: w_code = 4'hF;
            default:    w_match = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sreg        <= 12'd0;
            r_cnt         <= '0;
            r_seen        <= 4'd0;
            r_hex[0]      <= 4'd0;
            r_hex[1]      <= 4'd0;
            r_hex[2]      <= 4'd0;
            r_hex[3]      <= 4'd0;
            r_dp          <= 4'd0;
            r_frame_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_sreg        <= w_in;
            r_frame_valid <= 1'b0;
            r_err         <= 1'b0;

            if (w_changed) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Blanking (an == 0) is silently ignored.
            if (w_sample && (w_an != 4'd0)) begin
                if (!w_onehot || !w_match) begin
                    r_err  <= 1'b1;
                    r_seen <= 4'd0;
                end else begin
                    r_hex[w_idx] <= w_code;
                    r_dp[w_idx]  <= r_sreg[7];
                    if (w_seen_nxt == 4'b1111) begin
                        r_frame_valid <= 1'b1;
                        r_seen        <= 4'd0;
                    end else begin
                        r_seen <= w_seen_nxt;
                    end
                end
            end
        end
    end

    assign hex0        = r_hex[0];
    assign hex1        = r_hex[1];
    assign hex2        = r_hex[2];
    assign hex3        = r_hex[3];
    assign dp_out      = r_dp;
    assign frame_valid = r_frame_valid;
    assign err         = r_err;

endmodule
`default_nettype wire
